// File: rtl/stack_op_scheduler.sv
// Front-end controller for the 4-entry display stack: conditions four raw buttons,
// arbitrates them and issues one validated push/pop/popmath/swap at a time.
module stack_op_scheduler #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned CNT_W           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_push,
    input  logic             btn_pop,
    input  logic             btn_popmath,
    input  logic             btn_swap,
    output logic             op_push,
    output logic             op_pop,
    output logic             op_popmath,
    output logic             op_swap,
    output logic             load,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow,
    output logic [DEPTH-1:0] enable,
    output logic             busy
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COMMIT, S_WAIT_REL} state_t;
    typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_POPMATH, OP_SWAP} op_t;

    state_t           r_state, w_state_next;
    op_t              r_op, w_win;
    logic [3:0]       w_btn;
    logic [3:0]       r_sync1, r_sync2;
    logic [3:0]       r_db, r_db_q;
    logic [DB_W-1:0]  r_dbcnt [4];
    logic [3:0]       w_press;
    logic             w_valid;
    logic [CNT_W-1:0] r_count, w_cnt_next;
    logic [DEPTH-1:0] r_enable, w_en_next;
    logic             r_overflow, r_underflow;

    // Bit 0 is the highest-priority button (push), bit 3 the lowest (swap).
    assign w_btn = {btn_swap, btn_popmath, btn_pop, btn_push};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_q  <= '0;
            for (int unsigned i = 0; i < 4; i++) r_dbcnt[i] <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db;
            for (int unsigned i = 0; i < 4; i++) begin
                if (r_sync2[i] != r_db[i]) begin
                    if (r_dbcnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_db[i]    <= r_sync2[i];
                        r_dbcnt[i] <= '0;
                    end else begin
                        r_dbcnt[i] <= r_dbcnt[i] + 1'b1;
                    end
                end else begin
                    r_dbcnt[i] <= '0;
                end
            end
        end
    end

    assign w_press = r_db & ~r_db_q;

    always_comb begin
        w_win = OP_SWAP;
        if (w_press[0])      w_win = OP_PUSH;
        else if (w_press[1]) w_win = OP_POP;
        else if (w_press[2]) w_win = OP_POPMATH;
    end

    always_comb begin
        w_valid = 1'b0;
        case (r_op)
            OP_PUSH:    w_valid = (r_count != CNT_W'(DEPTH));
            OP_POP:     w_valid = (r_count != '0);
            OP_POPMATH: w_valid = (r_count >= CNT_W'(2));
            OP_SWAP:    w_valid = (r_count >= CNT_W'(2));
            default:    w_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        op_push      = 1'b0;
        op_pop       = 1'b0;
        op_popmath   = 1'b0;
        op_swap      = 1'b0;
        load         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_press) w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_valid) begin
                    op_push      = (r_op == OP_PUSH);
                    op_pop       = (r_op == OP_POP);
                    op_popmath   = (r_op == OP_POPMATH);
                    op_swap      = (r_op == OP_SWAP);
                    w_state_next = S_COMMIT;
                end else begin
                    w_state_next = S_WAIT_REL;
                end
            end
            S_COMMIT: begin
                load         = 1'b1;
                w_state_next = S_WAIT_REL;
            end
            S_WAIT_REL: begin
                if (r_db == '0) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_next = r_count;
        if (r_state == S_COMMIT) begin
            case (r_op)
                OP_PUSH:    w_cnt_next = r_count + 1'b1;
                OP_POP:     w_cnt_next = r_count - 1'b1;
                OP_POPMATH: w_cnt_next = r_count - 1'b1;
                default:    w_cnt_next = r_count;
            endcase
        end
        for (int unsigned i = 0; i < DEPTH; i++) w_en_next[i] = (w_cnt_next > CNT_W'(i));
    end

    // Flags are kept mutually exclusive by clearing the other whenever one is set.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op        <= OP_PUSH;
            r_count     <= '0;
            r_enable    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count  <= w_cnt_next;
            r_enable <= w_en_next;
            if (r_state == S_IDLE && (|w_press)) r_op <= w_win;
            if (r_state == S_ISSUE && !w_valid) begin
                r_overflow  <= (r_op == OP_PUSH);
                r_underflow <= (r_op != OP_PUSH);
            end
            if (r_state == S_COMMIT) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end
        end
    end

    assign count     = r_count;
    assign enable    = r_enable;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_stack_op_scheduler.sv
// Bench for stack_op_scheduler: directed scenarios plus random button transactions
// checked against a transaction-level stack-count model.
module tb_stack_op_scheduler;

    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int DBC   = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             btn_push = 1'b0, btn_pop = 1'b0, btn_popmath = 1'b0, btn_swap = 1'b0;
    logic             op_push, op_pop, op_popmath, op_swap, load;
    logic [CNT_W-1:0] count;
    logic             overflow, underflow, busy;
    logic [DEPTH-1:0] enable;

    stack_op_scheduler #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DEBOUNCE_CYCLES(DBC)) dut (
        .clk(clk), .reset(reset),
        .btn_push(btn_push), .btn_pop(btn_pop), .btn_popmath(btn_popmath), .btn_swap(btn_swap),
        .op_push(op_push), .op_pop(op_pop), .op_popmath(op_popmath), .op_swap(op_swap),
        .load(load), .count(count), .overflow(overflow), .underflow(underflow),
        .enable(enable), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: counts strobes and checks per-cycle invariants.
    int n_op [4];
    int n_load, op_cyc, load_cyc, cnt_at_load, cnt_after_load;
    logic prev_load = 1'b0;

    always @(negedge clk) begin
        if (op_push)    n_op[0]++;
        if (op_pop)     n_op[1]++;
        if (op_popmath) n_op[2]++;
        if (op_swap)    n_op[3]++;
        if (op_push | op_pop | op_popmath | op_swap) op_cyc = cyc;
        if (load) begin
            n_load++;
            load_cyc    = cyc;
            cnt_at_load = int'(count);
        end
        if (prev_load) cnt_after_load = int'(count);
        prev_load = load;
        check("strobe_onehot", int'($countones({op_push, op_pop, op_popmath, op_swap, load}) <= 1), 1);
        check("count_range", int'(count <= DEPTH), 1);
        check("flags_exclusive", int'(overflow & underflow), 0);
        check("enable_therm", int'(enable), (1 << count) - 1);
    end

    // Reference model: stack occupancy and sticky flags.
    int m_count = 0;
    int m_ovf   = 0;
    int m_udf   = 0;

    function automatic int pick(input bit [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_op(input int op, output int valid);
        int need;
        need  = (op == 0) ? 0 : (op == 1 ? 1 : 2);
        valid = (op == 0) ? int'(m_count < DEPTH) : int'(m_count >= need);
        if (valid != 0) begin
            if (op == 0)      m_count = m_count + 1;
            else if (op != 3) m_count = m_count - 1;
            m_ovf = 0;
            m_udf = 0;
        end else begin
            m_ovf = (op == 0) ? 1 : 0;
            m_udf = (op == 0) ? 0 : 1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input bit [3:0] v);
        btn_push    = v[0];
        btn_pop     = v[1];
        btn_popmath = v[2];
        btn_swap    = v[3];
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 4; i++) n_op[i] = 0;
        n_load = 0; op_cyc = -1; load_cyc = -1; cnt_at_load = -1; cnt_after_load = -1;
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 60) begin
            tick(1);
            k++;
        end
        check({tag, "_idle_timeout"}, int'(busy), 0);
        tick(2);
    endtask

    task automatic finish_txn(input int w, input int old, input string tag);
        int v;
        wait_idle(tag);
        model_op(w, v);
        for (int j = 0; j < 4; j++)
            check($sformatf("%s_op%0d", tag, j), n_op[j], (v != 0 && j == w) ? 1 : 0);
        check({tag, "_nload"}, n_load, v);
        if (v != 0) begin
            check({tag, "_op_to_load"}, load_cyc - op_cyc, 1);
            check({tag, "_cnt_at_load"}, cnt_at_load, old);
            check({tag, "_cnt_after_load"}, cnt_after_load, m_count);
        end
        check({tag, "_count"}, int'(count), m_count);
        check({tag, "_overflow"}, int'(overflow), m_ovf);
        check({tag, "_underflow"}, int'(underflow), m_udf);
    endtask

    task automatic press(input bit [3:0] v, input int hold, input string tag);
        int old;
        old = m_count;
        clear_mon();
        set_btns(v);
        tick(hold);
        if (hold >= 12) check({tag, "_busy_held"}, int'(busy), 1);
        set_btns(4'b0000);
        finish_txn(pick(v), old, tag);
    endtask

    task automatic glitch(input int b, input int len, input string tag);
        bit [3:0] v;
        int       old;
        old  = m_count;
        v    = '0;
        v[b] = 1'b1;
        clear_mon();
        set_btns(v);
        tick(len);
        set_btns(4'b0000);
        tick(12);
        check({tag, "_nops"}, n_op[0] + n_op[1] + n_op[2] + n_op[3], 0);
        check({tag, "_nload"}, n_load, 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_count"}, int'(count), old);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [3:0] v;
        int       r, old, found;
        clear_mon();
        tick(3);
        check("rst_count", int'(count), 0);
        check("rst_enable", int'(enable), 0);
        check("rst_flags", int'({overflow, underflow}), 0);
        check("rst_strobes", int'({op_push, op_pop, op_popmath, op_swap, load}), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        tick(2);

        for (int i = 0; i < 4; i++) press(4'b0001, 14, $sformatf("push%0d", i));
        check("full_enable", int'(enable), 15);
        press(4'b0001, 14, "push_full");
        press(4'b0010, 14, "pop_after_ovf");

        press(4'b0010, 50, "pop_held50");
        glitch(3, 3, "swap_glitch3");

        press(4'b0010, 14, "pop_to1");
        press(4'b1000, 14, "swap_udf");
        press(4'b0001, 14, "push_clear_udf");
        press(4'b1000, 14, "swap_ok");

        // Push and pop together, pop bouncing while held.
        old = m_count;
        clear_mon();
        set_btns(4'b0011);
        tick(12);
        for (int i = 0; i < 2; i++) begin
            btn_pop = 1'b0; tick(2);
            btn_pop = 1'b1; tick(2);
        end
        set_btns(4'b0000);
        finish_txn(0, old, "push_pop_bounce");

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 9);
            v = '0;
            v[(r < 4) ? 0 : (r < 6 ? 1 : (r < 8 ? 2 : 3))] = 1'b1;
            if ($urandom_range(0, 3) == 0) v[$urandom_range(0, 3)] = 1'b1;
            if ($urandom_range(0, 7) == 0) glitch($urandom_range(0, 3), $urandom_range(1, 3), $sformatf("rglitch%0d", t));
            press(v, $urandom_range(10, 30), $sformatf("rnd%0d", t));
        end

        for (int i = 0; i < 4 && m_count < 2; i++) press(4'b0001, 14, "pre_rst_push");
        clear_mon();
        btn_popmath = 1'b1;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            @(negedge clk);
            if (op_popmath) found = 1;
        end
        check("popmath_seen", found, 1);
        reset = 1'b1;
        tick(1);
        check("midop_rst_strobes", int'({op_push, op_pop, op_popmath, op_swap, load}), 0);
        check("midop_rst_count", int'(count), 0);
        check("midop_rst_enable", int'(enable), 0);
        check("midop_rst_flags", int'({overflow, underflow}), 0);
        check("midop_rst_busy", int'(busy), 0);
        check("midop_rst_noload", n_load, 0);
        m_count = 0; m_ovf = 0; m_udf = 0;
        tick(1);
        reset = 1'b0;
        clear_mon();
        tick(14);
        btn_popmath = 1'b0;
        finish_txn(2, 0, "held_across_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
